// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the ALU sequencer: opcodes, FSM states and
// the settle-counter width.
package alu_seq_pkg;

    localparam logic [1:0] OP_XOR     = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b01;
    localparam logic [1:0] OP_XOR_ALT = 2'b10;
    localparam logic [1:0] OP_SUB     = 2'b11;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/alu_sequencer.sv
// Feeds registered operands to an external combinational ALU, waits a fixed
// number of cycles for it to settle, then presents the captured result.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [15:0] cmd_a,
    input  logic [15:0] cmd_b,
    input  logic        cmd_chain,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [1:0]  alu_op,
    input  logic [16:0] alu_rout,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [16:0] res_data,
    output logic        res_zero
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [15:0]       alu_a_q, alu_b_q, chain_q;
    logic [1:0]        alu_op_q;
    logic              chain_ok_q;
    logic [16:0]       res_data_q;
    logic              res_zero_q;
    logic              accept;
    logic              settle_done;

    assign accept      = cmd_valid && cmd_ready;
    assign settle_done = (state_q == SETTLE) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)      state_d = SETTLE;
            SETTLE:  if (settle_done) state_d = RESP;
            RESP:    if (res_ready)   state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // Ready is masked by rst so nothing can be accepted while reset is held.
    always_comb begin
        cmd_ready = (state_q == IDLE) && !rst;
        res_valid = (state_q == RESP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            chain_q    <= '0;
            chain_ok_q <= 1'b0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
        end else begin
            if (accept) begin
                // A chained command with no prior result uses zero as operand A.
                if (cmd_chain) begin
                    alu_a_q <= chain_ok_q ? chain_q : 16'h0000;
                end else begin
                    alu_a_q <= cmd_a;
                end
                alu_b_q  <= cmd_b;
                alu_op_q <= cmd_op;
                cnt_q    <= SETTLE_LOAD;
            end else if (state_q == SETTLE) begin
                if (settle_done) begin
                    res_data_q <= alu_rout;
                    res_zero_q <= (alu_rout[15:0] == 16'h0000);
                    chain_q    <= alu_rout[15:0];
                    chain_ok_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign alu_op   = alu_op_q;
    assign res_data = res_data_q;
    assign res_zero = res_zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU beside the DUT.
module tb_alu_sequencer;

    localparam int SETTLE_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_a;
    logic [15:0] cmd_b;
    logic        cmd_chain;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [1:0]  alu_op;
    logic [16:0] alu_rout;
    logic        res_valid;
    logic        res_ready;
    logic [16:0] res_data;
    logic        res_zero;

    int n_chk = 0;
    int n_err = 0;
    logic [16:0] exp_q[$];
    logic [15:0] chain_m;
    logic        chain_ok_m;

    always #5 clk = ~clk;

    alu_sequencer #(.SETTLE_CYCLES(SETTLE_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_chain (cmd_chain),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_op    (alu_op),
        .alu_rout  (alu_rout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero)
    );

    function automatic logic [16:0] ref_alu(input logic [1:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            2'b01:   ref_alu = {1'b0, a} + {1'b0, b};
            2'b11:   ref_alu = {1'b0, a} + {1'b0, ~b} + 17'd1;
            default: ref_alu = {1'b0, a ^ b};
        endcase
    endfunction

    always_comb alu_rout = ref_alu(alu_op, alu_a, alu_b);

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction: accept, wait for result, optional backpressure, retire.
    task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic chain, input logic [16:0] exp, input int hold);
        int lat;
        logic [16:0] e;
        logic [15:0] a_eff;
        a_eff = chain ? (chain_ok_m ? chain_m : 16'h0000) : a;
        exp_q.push_back(exp);
        @(negedge clk);
        check_val("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = chain;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_a = 16'($urandom); cmd_b = 16'($urandom);
        cmd_op = 2'($urandom); cmd_chain = 1'($urandom);
        check_val("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        check_val("alu_a", 32'(alu_a), 32'(a_eff));
        check_val("alu_b", 32'(alu_b), 32'(b));
        check_val("alu_op", 32'(alu_op), 32'(op));
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency", 32'(lat), 32'(SETTLE_CYCLES));
        e = exp_q.pop_front();
        check_val("res_data", 32'(res_data), 32'(e));
        check_val("res_zero", 32'(res_zero), 32'(e[15:0] == 16'h0000));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            cmd_valid = (i == 2);
            @(posedge clk); #1;
            check_val("bp_valid", 32'(res_valid), 32'd1);
            check_val("bp_data", 32'(res_data), 32'(e));
            check_val("bp_ready", 32'(cmd_ready), 32'd0);
            check_val("bp_alu_a", 32'(alu_a), 32'(a_eff));
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check_val("retire_valid", 32'(res_valid), 32'd0);
        check_val("retire_ready", 32'(cmd_ready), 32'd1);
        chain_m    = e[15:0];
        chain_ok_m = 1'b1;
        $display("txn op=%0d a=0x%04h b=0x%04h chain=%0b -> res=0x%05h exp=0x%05h lat=%0d",
                 op, a_eff, b, chain, res_data, e, lat);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
        check_val({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check_val({tag, "_res_data"}, 32'(res_data), 32'd0);
        check_val({tag, "_res_zero"}, 32'(res_zero), 32'd0);
        check_val({tag, "_alu_a"}, 32'(alu_a), 32'd0);
        check_val({tag, "_alu_b"}, 32'(alu_b), 32'd0);
        check_val({tag, "_alu_op"}, 32'(alu_op), 32'd0);
    endtask

    initial begin
        logic [1:0]  r_op;
        logic [15:0] r_a, r_b, r_aeff;
        logic        r_ch;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = '0; cmd_b = '0;
        cmd_chain = 1'b0; res_ready = 1'b0;
        chain_m = '0; chain_ok_m = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("post_reset_ready", 32'(cmd_ready), 32'd1);

        run_cmd(2'b01, 16'h1234, 16'h0001, 1'b0, 17'h01235, 0);
        run_cmd(2'b01, 16'hFFFF, 16'h0001, 1'b0, 17'h10000, 0);
        run_cmd(2'b11, 16'h0005, 16'h0005, 1'b0, 17'h10000, 0);
        run_cmd(2'b00, 16'h00FF, 16'h0F0F, 1'b0, 17'h00FF0, 0);
        run_cmd(2'b10, 16'h00FF, 16'h0F0F, 1'b0, 17'h00FF0, 0);
        run_cmd(2'b01, 16'h0003, 16'h0004, 1'b0, 17'h00007, 5);
        run_cmd(2'b01, 16'hDEAD, 16'h0001, 1'b1, 17'h00008, 0);
        run_cmd(2'b11, 16'h0000, 16'h0001, 1'b0, 17'h0FFFF, 0);

        // Reset one cycle into SETTLE: the in-flight command must vanish.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 16'h1111; cmd_b = 16'h0001; cmd_chain = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        check_val("pre_rst_alu_a", 32'(alu_a), 32'h1111);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("mid_settle");
        chain_m = '0; chain_ok_m = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("mid_rst_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_val("no_result", 32'(res_valid), 32'd0);
        end

        run_cmd(2'b01, 16'hBEEF, 16'h0005, 1'b1, 17'h00005, 0);

        for (int i = 0; i < 8; i++) begin
            r_op = 2'($urandom);
            r_a  = 16'($urandom);
            r_b  = 16'($urandom);
            r_ch = 1'($urandom);
            r_aeff = r_ch ? chain_m : r_a;
            run_cmd(r_op, r_a, r_b, r_ch, ref_alu(r_op, r_aeff, r_b), int'($urandom_range(0, 2)));
        end

        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
